// File: rtl/fetch_byte_queue_if.sv
// Handshake/bus bundle between the I-cache read port, the fetch byte queue and the decoder.
// The cache/decoder side drives through master; the queue itself uses slave.
interface fetch_byte_queue_if #(
    parameter int DEPTH_BYTES = 256,
    parameter int IN_BYTES    = 64,
    parameter int OUT_BYTES   = 15
);
    localparam int CW = $clog2(DEPTH_BYTES) + 1;

    logic                     flush;
    logic                     enq_en;
    logic [6:0]               enq_cnt;
    logic [0:IN_BYTES*8-1]    enq_data;
    logic                     deq_en;
    logic [3:0]               deq_cnt;
    logic [0:OUT_BYTES*8-1]   deq_data;
    logic [CW-1:0]            used_cnt;
    logic [CW-1:0]            free_cnt;
    logic                     window_full;
    logic                     ovf_err;
    logic                     udf_err;

    modport master (
        output flush, enq_en, enq_cnt, enq_data, deq_en, deq_cnt,
        input  deq_data, used_cnt, free_cnt, window_full, ovf_err, udf_err
    );

    modport slave (
        input  flush, enq_en, enq_cnt, enq_data, deq_en, deq_cnt,
        output deq_data, used_cnt, free_cnt, window_full, ovf_err, udf_err
    );
endinterface

// File: rtl/fetch_byte_queue.sv
// Byte-granular circular buffer feeding the x86 decoder: up to one cache line in,
// 0..OUT_BYTES bytes out per cycle, oldest OUT_BYTES bytes shown left-aligned.
module fetch_byte_queue #(
    parameter int DEPTH_BYTES = 256,
    parameter int IN_BYTES    = 64,
    parameter int OUT_BYTES   = 15
) (
    input  logic               clk,
    input  logic               reset,
    fetch_byte_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH_BYTES);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic [PW-1:0] hd_q, hd_d;
    logic [PW-1:0] tl_q, tl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [CW-1:0] free;
    logic          enq_ok;
    logic          deq_ok;
    logic          wr_en;

    assign free = CW'(DEPTH_BYTES) - cnt_q;

    // Acceptance uses pre-cycle occupancy only, so same-cycle enq/deq never help each other.
    assign enq_ok = bus.enq_en && (bus.enq_cnt <= 7'(IN_BYTES)) && (CW'(bus.enq_cnt) <= free);
    assign deq_ok = bus.deq_en && (bus.deq_cnt <= 4'(OUT_BYTES)) && (CW'(bus.deq_cnt) <= cnt_q);
    assign wr_en  = enq_ok && !bus.flush && !reset;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hd_d  = hd_q;
        tl_d  = tl_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (bus.flush) begin
            hd_d  = '0;
            tl_d  = '0;
            cnt_d = '0;
        end else begin
            if (enq_ok) begin
                tl_d  = tl_q + PW'(bus.enq_cnt);
                cnt_d = cnt_d + CW'(bus.enq_cnt);
            end else if (bus.enq_en) begin
                ovf_d = 1'b1;
            end
            if (deq_ok) begin
                hd_d  = hd_q + PW'(bus.deq_cnt);
                cnt_d = cnt_d - CW'(bus.deq_cnt);
            end else if (bus.deq_en) begin
                udf_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // NOTE: the byte array has no reset; stale contents are hidden because reads are masked by cnt_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_BYTES; i++) begin
            if (wr_en && (i < int'(bus.enq_cnt))) begin
                mem_q[tl_q + PW'(i)] <= bus.enq_data[i*8 +: 8];
            end
        end
    end

    // Decode window reads straight from the array; bytes past occupancy read as zero.
    always_comb begin
        bus.deq_data = '0;
        for (int j = 0; j < OUT_BYTES; j++) begin
            if (CW'(j) < cnt_q) begin
                bus.deq_data[j*8 +: 8] = mem_q[hd_q + PW'(j)];
            end
        end
    end

    assign bus.used_cnt    = cnt_q;
    assign bus.free_cnt    = free;
    assign bus.window_full = (cnt_q >= CW'(OUT_BYTES));
    assign bus.ovf_err     = ovf_q;
    assign bus.udf_err     = udf_q;
endmodule

// File: tb/tb_fetch_byte_queue.sv
// Self-checking bench for fetch_byte_queue: byte-level reference model, expected
// state pushed to a scoreboard when a cycle is driven and compared after the edge.
module tb_fetch_byte_queue;
    localparam int DEPTH = 256;
    localparam int INB   = 64;
    localparam int OUTB  = 15;

    typedef struct {
        logic [8:0]        used;
        logic [8:0]        free;
        logic              wfull;
        logic [0:OUTB*8-1] data;
        logic              ovf;
        logic              udf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    fetch_byte_queue_if #(.DEPTH_BYTES(DEPTH), .IN_BYTES(INB), .OUT_BYTES(OUTB)) bus ();

    fetch_byte_queue #(.DEPTH_BYTES(DEPTH), .IN_BYTES(INB), .OUT_BYTES(OUTB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_err = 0;
    exp_t     sb_q[$];
    bit [7:0] mdl_q[$];
    bit       mdl_ovf = 1'b0;
    bit       mdl_udf = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare the DUT against the popped expectation.
    task automatic step(input bit rst, input bit fl, input bit ee, input int ec,
                        input logic [0:INB*8-1] ed, input bit de, input int dc);
        int   used;
        bit   eok, dok;
        exp_t e;
        reset        = rst;
        bus.flush    = fl;
        bus.enq_en   = ee;
        bus.enq_cnt  = 7'(ec);
        bus.enq_data = ed;
        bus.deq_en   = de;
        bus.deq_cnt  = 4'(dc);

        used = mdl_q.size();
        if (rst) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end else if (fl) begin
            mdl_q.delete();
        end else begin
            eok = ee && (ec <= INB) && (ec <= DEPTH - used);
            dok = de && (dc <= OUTB) && (dc <= used);
            if (ee && !eok) mdl_ovf = 1'b1;
            if (de && !dok) mdl_udf = 1'b1;
            if (dok) repeat (dc) void'(mdl_q.pop_front());
            if (eok) for (int i = 0; i < ec; i++) mdl_q.push_back(ed[i*8 +: 8]);
        end
        e.used  = 9'(mdl_q.size());
        e.free  = 9'(DEPTH - mdl_q.size());
        e.wfull = (mdl_q.size() >= OUTB);
        e.data  = '0;
        for (int j = 0; j < OUTB; j++) if (j < mdl_q.size()) e.data[j*8 +: 8] = mdl_q[j];
        e.ovf   = mdl_ovf;
        e.udf   = mdl_udf;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("used_cnt",    128'(bus.used_cnt),    128'(e.used));
        check("free_cnt",    128'(bus.free_cnt),    128'(e.free));
        check("window_full", 128'(bus.window_full), 128'(e.wfull));
        check("deq_data",    128'(bus.deq_data),    128'(e.data));
        check("ovf_err",     128'(bus.ovf_err),     128'(e.ovf));
        check("udf_err",     128'(bus.udf_err),     128'(e.udf));
    endtask

    function automatic logic [0:INB*8-1] ramp(input int start);
        logic [0:INB*8-1] d;
        for (int i = 0; i < INB; i++) d[i*8 +: 8] = 8'(start + i);
        return d;
    endfunction

    task automatic enq(input int n, input int start);
        step(1'b0, 1'b0, 1'b1, n, ramp(start), 1'b0, 0);
    endtask

    task automatic deq(input int n);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, n);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0);
    endtask

    logic [0:OUTB*8-1] win;

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0; bus.enq_en = 1'b0; bus.enq_cnt = '0; bus.enq_data = '0;
        bus.deq_en = 1'b0; bus.deq_cnt = '0;

        // Reset state
        do_reset();
        do_reset();
        check("rst_free", 128'(bus.free_cnt), 128'(DEPTH));
        check("rst_data", 128'(bus.deq_data), 128'(0));

        // Line of 00..3F, then concurrent deq 5 / enq 10
        enq(64, 8'h00);
        for (int j = 0; j < OUTB; j++) win[j*8 +: 8] = 8'(j);
        check("tp1_used", 128'(bus.used_cnt), 128'(64));
        check("tp1_data", 128'(bus.deq_data), 128'(win));
        step(1'b0, 1'b0, 1'b1, 10, ramp(8'h40), 1'b1, 5);
        check("tp2_used",  128'(bus.used_cnt), 128'(69));
        check("tp2_byte0", 128'(bus.deq_data[0:7]), 128'(8'h05));

        // Zero-count requests are legal no-ops; oversize enqueue is rejected
        step(1'b0, 1'b0, 1'b1, 0, '0, 1'b1, 0);
        enq(65, 8'h80);
        check("oversize_ovf", 128'(bus.ovf_err), 128'(1));

        // Wrap: hd=200, fill to 250, then to full, then reject one more
        do_reset();
        for (int k = 0; k < 3; k++) enq(64, k * 64);
        enq(8, 8'hC0);
        for (int k = 0; k < 13; k++) deq(15);
        deq(5);
        for (int k = 0; k < 3; k++) enq(64, 8'h11 + k * 64);
        enq(58, 8'h7A);
        check("wrap_used250", 128'(bus.used_cnt), 128'(250));
        enq(6, 8'hE0);
        check("full_free", 128'(bus.free_cnt), 128'(0));
        enq(1, 8'hAA);
        check("full_ovf",  128'(bus.ovf_err),  128'(1));
        check("full_used", 128'(bus.used_cnt), 128'(256));
        deq(15); deq(15); deq(15); deq(10);
        deq(15);
        deq(15);

        // Underflow at used=3, then flush with concurrent traffic at used=100
        do_reset();
        enq(3, 8'h30);
        deq(4);
        check("udf_flag", 128'(bus.udf_err), 128'(1));
        check("udf_used", 128'(bus.used_cnt), 128'(3));
        check("udf_tail", 128'(bus.deq_data[24:119]), 128'(0));
        enq(64, 8'h50);
        enq(33, 8'h90);
        step(1'b0, 1'b1, 1'b1, 64, ramp(8'h01), 1'b1, 15);
        check("flush_used", 128'(bus.used_cnt), 128'(0));
        check("flush_data", 128'(bus.deq_data), 128'(0));
        check("flush_udf",  128'(bus.udf_err),  128'(1));

        // Random legal traffic with occasional flush, then reset mid-stream
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            int used, ec, dc;
            logic [0:INB*8-1] d;
            used = mdl_q.size();
            for (int w = 0; w < INB / 4; w++) d[w*32 +: 32] = $urandom;
            ec = $urandom_range(((DEPTH - used) < INB) ? (DEPTH - used) : INB, 0);
            dc = $urandom_range((used < OUTB) ? used : OUTB, 0);
            step(1'b0, ($urandom_range(127, 0) == 0), ($urandom_range(3, 0) != 0), ec, d,
                 ($urandom_range(1, 0) != 0), dc);
        end
        check("rand_no_ovf", 128'(bus.ovf_err), 128'(0));
        check("rand_no_udf", 128'(bus.udf_err), 128'(0));
        enq(40, 8'h20);
        do_reset();
        check("midrst_data", 128'(bus.deq_data), 128'(0));
        enq(2, 8'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_byte_queue.md
Name: fetch_byte_queue

Overview:
- Byte-granular circular buffer between the instruction-cache read port and the x86 decoder.
- Accepts up to one 64-byte cache line per cycle, starting at any byte offset. Releases 0..15 consumed bytes per cycle.
- Always presents the oldest 15 bytes as a left-aligned decode window.
- Flush input discards all contents on a fetch redirect.

Parameters:
- DEPTH_BYTES, 256, capacity in bytes; power of two, at least 2*IN_BYTES.
- IN_BYTES, 64, maximum bytes enqueued per cycle (one cache line).
- OUT_BYTES, 15, decode window width in bytes (maximum x86 instruction length).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- flush  input  1  discard all queued bytes.
- enq_en  input  1  enqueue request.
- enq_cnt  input  7  number of bytes to enqueue, 0..IN_BYTES.
- enq_data  input  IN_BYTES*8  bytes; byte 0 in bits [0:7] (MSB-first, [0:N-1] ordering).
- deq_en  input  1  dequeue request.
- deq_cnt  input  4  number of bytes to release, 0..OUT_BYTES.
- deq_data  output  OUT_BYTES*8  oldest bytes; byte 0 is the queue head.
- used_cnt  output  $clog2(DEPTH_BYTES)+1  bytes held.
- free_cnt  output  $clog2(DEPTH_BYTES)+1  equals DEPTH_BYTES - used_cnt.
- window_full  output  1  high when used_cnt >= OUT_BYTES.
- ovf_err  output  1  sticky: a rejected enqueue occurred.
- udf_err  output  1  sticky: a rejected dequeue occurred.

Behaviour:
- Storage: DEPTH_BYTES x 8 array; head pointer hd and tail pointer tl, each $clog2(DEPTH_BYTES) bits, wrapping modulo DEPTH_BYTES; occupancy register cnt.
- Reset: hd=0, tl=0, cnt=0, ovf_err=0, udf_err=0. Outputs after reset: used_cnt=0, free_cnt=DEPTH_BYTES, window_full=0, deq_data=0.
- Enqueue acceptance:
  - Accepted when enq_en && enq_cnt <= free_cnt, using the pre-cycle free_cnt. A same-cycle dequeue does not create room.
  - Accepted enqueue writes byte i of enq_data to mem[(tl+i) mod DEPTH] for i < enq_cnt, then tl += enq_cnt.
  - enq_cnt > IN_BYTES, or enq_cnt > free_cnt, rejects the whole request: no partial write, ovf_err <= 1.
- Dequeue acceptance:
  - Accepted when deq_en && deq_cnt <= used_cnt, using the pre-cycle used_cnt. Bytes enqueued in the same cycle are not dequeuable.
  - Accepted dequeue does hd += deq_cnt.
  - Rejected dequeue: no pointer change, udf_err <= 1.
- Occupancy: cnt_next = cnt + accepted enq_cnt - accepted deq_cnt, both terms applied in the same cycle.
- Count of 0 with en=1 is a legal no-op and never sets an error.
- Flush:
  - Has priority over enq/deq in the same cycle: hd=tl=0, cnt=0; that cycle's enqueue and dequeue are discarded.
  - Sticky error flags are cleared only by reset.
- deq_data:
  - Combinational from hd and the memory array; byte j = mem[(hd+j) mod DEPTH] when j < cnt, else 8'h00.
  - Updates the cycle after any pointer change (zero-cycle read, one-cycle write-to-read latency).
- Wrap-around: writes and reads spanning index DEPTH-1 -> 0 are contiguous in logical order.
- Full: cnt == DEPTH_BYTES gives free_cnt=0. Empty: cnt == 0 gives deq_data all zero.
- Reset mid-operation: all state returns to reset values on the next edge. Memory contents are not cleared, but are masked by cnt=0.

Test Plan:
- Reset, then enqueue 64 bytes 00..3F -> next cycle used_cnt=64, free_cnt=192, window_full=1, deq_data=00 01 .. 0E.
- After that enqueue, dequeue 5 plus enqueue 10 bytes 40..49 in the same cycle -> used_cnt=69, deq_data starts 05.
- Wrap: fill to 250 used with hd=200, then enqueue 6 -> used_cnt=256, free_cnt=0; next enqueue of 1 rejected, ovf_err=1, state unchanged.
- Underflow: used_cnt=3, deq_cnt=4 -> udf_err=1, used_cnt stays 3, deq_data bytes 3..14 = 00.
- Flush concurrent with enq 64 and deq 15 at used=100 -> next cycle used_cnt=0, deq_data=0, error flags unchanged.
- Random mixed enq/deq for 10k cycles against a byte-level reference model -> deq_data and used_cnt match every cycle, and there are no errors when requests respect the counts.
